// File: rtl/buf_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : buf_seq_ctrl
//  Description : Sequencer for the double-banked source/destination buffers of
//                the MNIST inference datapath. Sweeps every input word of the
//                selected source bank once per output neuron, marks the start
//                and end of each MAC accumulation, and issues the destination
//                write a fixed pipeline latency after each accumulation ends.
//  Revision    : 1.0 - initial release
// ============================================================================
module buf_seq_ctrl #(
    parameter int AW   = 12,    // per-bank word address width
    parameter int PIPE = 3      // exec(last) -> outr latency, 1..8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [AW:0]   in_size,
    input  logic [AW:0]   out_size,
    input  logic          src_bank,
    input  logic          dst_bank,
    output logic          busy,
    output logic          exec,
    output logic [AW:0]   ia,
    output logic          init,
    output logic          last,
    output logic          outr,
    output logic [AW:0]   oa,
    output logic          done
);

    // ------------------------------------------------------------------------
    // Constants and types
    // ------------------------------------------------------------------------
    localparam logic [AW:0] C_ONE = {{AW{1'b0}}, 1'b1};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_FIN   = 2'd3
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t        state_q,    state_d;
    logic [AW:0]   i_q,        i_d;         // input-word index within a neuron
    logic [AW:0]   o_q,        o_d;         // output-neuron index
    logic [AW:0]   in_size_q,  in_size_d;
    logic [AW:0]   out_size_q, out_size_d;
    logic          src_bank_q, src_bank_d;
    logic          dst_bank_q, dst_bank_d;

    // Delay line carrying {valid, destination address}; index PIPE-1 is the
    // tail that drives outr/oa directly, so those outputs are registered.
    logic          dl_valid_q [PIPE];
    logic          dl_valid_d [PIPE];
    logic [AW:0]   dl_addr_q  [PIPE];
    logic [AW:0]   dl_addr_d  [PIPE];

    // ------------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------------
    logic          w_exec;
    logic          w_i_last;
    logic          w_o_last;
    logic          w_dl_pending;

    // End-of-row / end-of-layer detection against the latched sizes.
    always_comb begin
        w_exec   = (state_q == S_RUN);
        w_i_last = (i_q == (in_size_q - C_ONE));
        w_o_last = (o_q == (out_size_q - C_ONE));
    end

    // Anything still travelling in the delay line ahead of the tail; the tail
    // itself leaves this cycle, so done can follow the final outr directly.
    always_comb begin
        w_dl_pending = 1'b0;
        for (int k = 0; k < PIPE - 1; k++) begin
            w_dl_pending = w_dl_pending | dl_valid_q[k];
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: FSM, counters and configuration latch
    // ------------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        i_d        = i_q;
        o_d        = o_q;
        in_size_d  = in_size_q;
        out_size_d = out_size_q;
        src_bank_d = src_bank_q;
        dst_bank_d = dst_bank_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    in_size_d  = in_size;
                    out_size_d = out_size;
                    src_bank_d = src_bank;
                    dst_bank_d = dst_bank;
                    i_d        = '0;
                    o_d        = '0;
                    // An empty layer has nothing to sweep: report done at once.
                    if ((in_size == '0) || (out_size == '0)) begin
                        state_d = S_FIN;
                    end else begin
                        state_d = S_RUN;
                    end
                end
            end

            S_RUN: begin
                if (w_i_last) begin
                    i_d = '0;
                    if (w_o_last) begin
                        state_d = S_DRAIN;
                    end else begin
                        o_d = o_q + C_ONE;
                    end
                end else begin
                    i_d = i_q + C_ONE;
                end
            end

            S_DRAIN: begin
                if (!w_dl_pending) begin
                    state_d = S_FIN;
                end
            end

            S_FIN: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Delay line shift: a new entry enters only when an accumulation ends
    // ------------------------------------------------------------------------
    always_comb begin
        dl_valid_d[0] = last;
        dl_addr_d[0]  = last ? {dst_bank_q, o_q[AW-1:0]} : '0;
        for (int k = 1; k < PIPE; k++) begin
            dl_valid_d[k] = dl_valid_q[k-1];
            dl_addr_d[k]  = dl_addr_q[k-1];
        end
    end

    // ------------------------------------------------------------------------
    // State registers with asynchronous clear
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            i_q        <= '0;
            o_q        <= '0;
            in_size_q  <= '0;
            out_size_q <= '0;
            src_bank_q <= 1'b0;
            dst_bank_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            i_q        <= i_d;
            o_q        <= o_d;
            in_size_q  <= in_size_d;
            out_size_q <= out_size_d;
            src_bank_q <= src_bank_d;
            dst_bank_q <= dst_bank_d;
        end
    end

    // Delay line registers; reset discards every in-flight write request.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < PIPE; k++) begin
                dl_valid_q[k] <= 1'b0;
                dl_addr_q[k]  <= '0;
            end
        end else begin
            for (int k = 0; k < PIPE; k++) begin
                dl_valid_q[k] <= dl_valid_d[k];
                dl_addr_q[k]  <= dl_addr_d[k];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Outputs decoded from registered state
    // ------------------------------------------------------------------------
    always_comb begin
        exec = w_exec;
        busy = (state_q == S_RUN) || (state_q == S_DRAIN);
        done = (state_q == S_FIN);
        init = w_exec && (i_q == '0);
        last = w_exec && w_i_last;
        // Only the low AW bits of the counter reach the bus; the bank bit is
        // the latched selection, so a 4096-word sweep never spills into it.
        ia   = w_exec ? {src_bank_q, i_q[AW-1:0]} : '0;
        outr = dl_valid_q[PIPE-1];
        oa   = dl_addr_q[PIPE-1];
    end

endmodule
`default_nettype wire

// File: tb/tb_buf_seq_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_buf_seq_ctrl
//  Description : Self-checking bench for buf_seq_ctrl. A timeline model derives
//                every output per cycle from the accepted start and the layer
//                sizes; directed scenarios also pin literal expectations.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_buf_seq_ctrl;

    localparam int AW   = 12;
    localparam int PIPE = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic [AW:0]   in_size;
    logic [AW:0]   out_size;
    logic          src_bank;
    logic          dst_bank;
    logic          busy, exec, init, last, outr, done;
    logic [AW:0]   ia, oa;

    buf_seq_ctrl #(.AW(AW), .PIPE(PIPE)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_size(in_size), .out_size(out_size),
        .src_bank(src_bank), .dst_bank(dst_bank),
        .busy(busy), .exec(exec), .ia(ia), .init(init), .last(last),
        .outr(outr), .oa(oa), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------------
    // Timeline model: one layer at a time, described by cycle ranges
    // ------------------------------------------------------------------------
    int   m_n, m_m;
    bit   m_sb, m_db;
    int   exec_lo, exec_hi, busy_lo, busy_hi, done_at, idle_at;
    bit   chk_en = 1'b0;

    function automatic void m_clear();
        exec_lo = 1; exec_hi = 0;
        busy_lo = 1; busy_hi = 0;
        done_at = -1;
        idle_at = 0;
    endfunction

    function automatic void m_accept(input int c);
        m_n  = int'(in_size);
        m_m  = int'(out_size);
        m_sb = src_bank;
        m_db = dst_bank;
        if (m_n == 0 || m_m == 0) begin
            exec_lo = 1; exec_hi = 0;
            busy_lo = 1; busy_hi = 0;
            done_at = c + 1;
        end else begin
            exec_lo = c + 1;
            exec_hi = c + m_n * m_m;
            busy_lo = c + 1;
            busy_hi = exec_hi + PIPE;
            done_at = busy_hi + 1;
        end
        idle_at = done_at + 1;
    endfunction

    // Observation log for literal checks in the directed scenarios.
    int          ex_cyc[$];
    logic [AW:0] ex_ia[$];
    bit          ex_init[$];
    bit          ex_last[$];
    int          or_cyc[$];
    logic [AW:0] or_oa[$];
    int          dn_cyc[$];
    int          bz_first, bz_last, bz_cnt;
    int          st_cyc;

    task automatic clear_log();
        ex_cyc.delete(); ex_ia.delete(); ex_init.delete(); ex_last.delete();
        or_cyc.delete(); or_oa.delete(); dn_cyc.delete();
        bz_first = -1; bz_last = -1; bz_cnt = 0;
    endtask

    // Compare process: every cycle, DUT outputs against the model.
    always @(negedge clk) begin
        bit e_exec, e_outr;
        int k, j, ei, eo;
        if (chk_en) begin
            if (reset) begin
                chk("rst_exec", exec, 0);
                chk("rst_init", init, 0);
                chk("rst_last", last, 0);
                chk("rst_outr", outr, 0);
                chk("rst_busy", busy, 0);
                chk("rst_done", done, 0);
                chk("rst_ia", ia, 0);
                chk("rst_oa", oa, 0);
                m_clear();
            end else begin
                if (start && cyc >= idle_at) m_accept(cyc);
                e_exec = (cyc >= exec_lo) && (cyc <= exec_hi);
                j      = cyc - PIPE;
                e_outr = (j >= exec_lo) && (j <= exec_hi) && (((j - exec_lo) % m_n) == m_n - 1);
                chk("exec", exec, e_exec);
                chk("busy", busy, (cyc >= busy_lo) && (cyc <= busy_hi));
                chk("done", done, cyc == done_at);
                chk("outr", outr, e_outr);
                if (e_exec) begin
                    k  = cyc - exec_lo;
                    ei = k % m_n;
                    chk("ia", ia, {m_sb, 12'(ei)});
                    chk("init", init, ei == 0);
                    chk("last", last, ei == m_n - 1);
                end else begin
                    chk("init_idle", init, 0);
                    chk("last_idle", last, 0);
                end
                if (e_outr) begin
                    eo = (j - exec_lo) / m_n;
                    chk("oa", oa, {m_db, 12'(eo)});
                end
                if (exec) begin
                    ex_cyc.push_back(cyc); ex_ia.push_back(ia);
                    ex_init.push_back(init); ex_last.push_back(last);
                end
                if (outr) begin
                    or_cyc.push_back(cyc); or_oa.push_back(oa);
                end
                if (done) dn_cyc.push_back(cyc);
                if (busy) begin
                    if (bz_cnt == 0) bz_first = cyc;
                    bz_last = cyc;
                    bz_cnt++;
                end
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input int n, input int m, input bit sb, input bit db);
        in_size  = 13'(n);
        out_size = 13'(m);
        src_bank = sb;
        dst_bank = db;
        start    = 1'b1;
        st_cyc   = cyc;
        step();
        start    = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        int w = 0;
        while (cyc < idle_at && w < budget) begin
            step();
            w++;
        end
        chk("wait_idle_in_budget", w < budget, 1);
    endtask

    // Literal expectations for in_size=4, out_size=2, src=1, dst=0.
    task automatic check_scn1(input string tag);
        chk({tag, "_nexec"}, ex_cyc.size(), 8);
        if (ex_cyc.size() == 8) begin
            chk({tag, "_first_exec"}, ex_cyc[0] - st_cyc, 1);
            chk({tag, "_exec_span"}, ex_cyc[7] - ex_cyc[0], 7);
            for (int q = 0; q < 8; q++) begin
                chk({tag, "_ia"}, ex_ia[q], 13'h1000 + 13'(q % 4));
                chk({tag, "_init"}, ex_init[q], (q == 0) || (q == 4));
                chk({tag, "_last"}, ex_last[q], (q == 3) || (q == 7));
            end
        end
        chk({tag, "_nout"}, or_cyc.size(), 2);
        if (or_cyc.size() == 2 && ex_cyc.size() == 8) begin
            chk({tag, "_oa0"}, or_oa[0], 13'h0000);
            chk({tag, "_oa1"}, or_oa[1], 13'h0001);
            chk({tag, "_lat0"}, or_cyc[0] - ex_cyc[3], 3);
            chk({tag, "_lat1"}, or_cyc[1] - ex_cyc[7], 3);
            chk({tag, "_busy_first"}, bz_first, ex_cyc[0]);
            chk({tag, "_busy_last"}, bz_last, or_cyc[1]);
            chk({tag, "_busy_cnt"}, bz_cnt, or_cyc[1] - ex_cyc[0] + 1);
        end
        chk({tag, "_ndone"}, dn_cyc.size(), 1);
        if (dn_cyc.size() == 1 && or_cyc.size() == 2)
            chk({tag, "_done_after_outr"}, dn_cyc[0] - or_cyc[1], 1);
    endtask

    // Global watchdog.
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1);
    end

    // ------------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------------
    initial begin
        int n, m, total, cnt;
        bit do_rst;
        int rst_at;

        reset = 1'b1; start = 1'b0; in_size = '0; out_size = '0;
        src_bank = 1'b0; dst_bank = 1'b0;
        m_clear();
        clear_log();
        step(); step();
        chk_en = 1'b1;
        step(); step();
        reset = 1'b0;
        step();

        // Scenario 1: basic two-neuron sweep.
        clear_log();
        pulse_start(4, 2, 1'b1, 1'b0);
        wait_idle(100);
        check_scn1("s1");

        // Scenario 2: single-input neurons, back-to-back writes.
        clear_log();
        pulse_start(1, 3, 1'b0, 1'b1);
        wait_idle(100);
        chk("s2_nexec", ex_cyc.size(), 3);
        cnt = 0;
        foreach (ex_init[q]) cnt += (ex_init[q] && ex_last[q]) ? 1 : 0;
        chk("s2_init_last_all", cnt, 3);
        chk("s2_nout", or_cyc.size(), 3);
        if (or_cyc.size() == 3) begin
            chk("s2_oa0", or_oa[0], 13'h1000);
            chk("s2_oa1", or_oa[1], 13'h1001);
            chk("s2_oa2", or_oa[2], 13'h1002);
            chk("s2_consecutive", or_cyc[2] - or_cyc[0], 2);
        end

        // Scenario 3: empty layers.
        clear_log();
        pulse_start(0, 5, 1'b1, 1'b1);
        wait_idle(20);
        chk("s3a_nexec", ex_cyc.size(), 0);
        chk("s3a_nout", or_cyc.size(), 0);
        chk("s3a_ndone", dn_cyc.size(), 1);
        if (dn_cyc.size() == 1) chk("s3a_done_cyc", dn_cyc[0] - st_cyc, 1);
        clear_log();
        pulse_start(7, 0, 1'b0, 1'b1);
        wait_idle(20);
        chk("s3b_nexec", ex_cyc.size(), 0);
        chk("s3b_nout", or_cyc.size(), 0);
        chk("s3b_ndone", dn_cyc.size(), 1);
        if (dn_cyc.size() == 1) chk("s3b_done_cyc", dn_cyc[0] - st_cyc, 1);

        // Scenario 4: full 4096-word bank.
        clear_log();
        pulse_start(4096, 1, 1'b0, 1'b0);
        wait_idle(5000);
        chk("s4_nexec", ex_cyc.size(), 4096);
        if (ex_cyc.size() == 4096) begin
            chk("s4_ia_first", ex_ia[0], 13'h0000);
            chk("s4_ia_end", ex_ia[4095], 13'h0FFF);
            chk("s4_last_end", ex_last[4095], 1);
        end
        cnt = 0;
        foreach (ex_ia[q]) cnt += ex_ia[q][AW] ? 1 : 0;
        chk("s4_bank_bit", cnt, 0);
        cnt = 0;
        foreach (ex_last[q]) cnt += ex_last[q] ? 1 : 0;
        chk("s4_nlast", cnt, 1);
        chk("s4_nout", or_cyc.size(), 1);
        if (or_cyc.size() == 1) chk("s4_oa", or_oa[0], 13'h0000);

        // Scenario 5: start and size changes while busy are ignored.
        clear_log();
        pulse_start(4, 2, 1'b1, 1'b0);
        step();
        start = 1'b1; in_size = 13'd7; out_size = 13'd9; src_bank = 1'b0; dst_bank = 1'b1;
        step();
        start = 1'b0; in_size = 13'd1; out_size = 13'd0;
        step(); step();
        start = 1'b1;
        step();
        start = 1'b0;
        wait_idle(100);
        check_scn1("s5");

        // Scenario 6: reset two cycles after the first last.
        clear_log();
        pulse_start(4, 2, 1'b1, 1'b0);
        repeat (5) step();
        reset = 1'b1;
        #1;
        chk("s6_imm_exec", exec, 0);
        chk("s6_imm_busy", busy, 0);
        chk("s6_imm_ia", ia, 0);
        step(); step();
        reset = 1'b0;
        repeat (10) step();
        chk("s6_nout", or_cyc.size(), 0);
        chk("s6_ndone", dn_cyc.size(), 0);
        clear_log();
        pulse_start(4, 2, 1'b1, 1'b0);
        wait_idle(100);
        check_scn1("s6r");

        // Randomized layers with noise on the inputs and occasional resets.
        for (int r = 0; r < 40; r++) begin
            n = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 12);
            m = ($urandom_range(0, 5) == 0) ? 0 : $urandom_range(1, 5);
            total  = n * m;
            do_rst = ($urandom_range(0, 7) == 0);
            rst_at = $urandom_range(0, total + PIPE);
            pulse_start(n, m, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            for (int t = 0; t < total + PIPE; t++) begin
                start    = ($urandom_range(0, 3) == 0);
                in_size  = 13'($urandom_range(0, 12));
                out_size = 13'($urandom_range(0, 5));
                src_bank = 1'($urandom_range(0, 1));
                dst_bank = 1'($urandom_range(0, 1));
                if (do_rst && t == rst_at) begin
                    start = 1'b0;
                    reset = 1'b1;
                    step(); step();
                    reset = 1'b0;
                end
                step();
            end
            start = 1'b0;
            wait_idle(400);
        end
        repeat (5) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
